pwm_carrier_counter: RTL

- Carrier generator that sits directly downstream of the PWM mode definitions. It consumes the `_count_mode` and `_mask_mode` enums from `pwm_pkg`.
- Produces the shared carrier value, direction, and min/max event pulses that the compare/dead-time stages consume.
- Period, prescaler and count mode are double-buffered. The shadows reload only on carrier min/max events, filtered by the mask mode, so reconfiguration is glitch-free.

---
 rtl/pwm_carrier_counter.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_carrier_counter.sv
// -----------------------------------------------------------------------------
// pwm_pkg / pwm_carrier_counter
//
// pwm_pkg holds the count-mode and mask-mode encodings shared by the PWM
// stages.
//
// pwm_carrier_counter generates the shared PWM carrier. It produces the
// counter value, the count direction, and min/max event pulses for the
// compare and dead-time stages.
//
// Period, prescaler and count mode are double-buffered. The shadows reload
// only on a carrier min/max event, filtered by mask_mode, so a
// reconfiguration never cuts a carrier cycle short.
//
// Optional feature (macro PWM_SYNC_IN_EN):
//   Adds the sync_in port. A sync_in pulse while en=1 re-phases the carrier:
//   carrier=0, dir=1, prescaler=0, all shadows reload, and ev_min and upd
//   are asserted.
//
// Parameters:
//   CNT_WIDTH   - width of carrier and period
//   PRESC_WIDTH - width of prescaler reload value
//
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   en         - count enable; 0 freezes prescaler and carrier
//   count_mode - pwm_pkg::_count_mode encoding, captured into shadow on reload
//   mask_mode  - pwm_pkg::_mask_mode encoding, used live
//   period_in  - carrier peak value P, captured on reload
//   presc_in   - tick divider D (tick every D+1 cycles), captured on reload
//   sync_in    - (PWM_SYNC_IN_EN only) carrier re-phase request
//   carrier    - current counter value
//   dir        - 1 = counting up, 0 = counting down
//   ev_min     - one-cycle pulse when carrier enters 0
//   ev_max     - one-cycle pulse when carrier enters P
//   upd        - one-cycle pulse on the cycle the shadows were reloaded
// -----------------------------------------------------------------------------

package pwm_pkg;
  typedef enum logic [1:0] {
    COUNT_UP     = 2'b00,
    COUNT_DOWN   = 2'b01,
    COUNT_UPDOWN = 2'b10
  } _count_mode;

  typedef enum logic [1:0] {
    NO_MASK     = 2'b00,
    MIN_MASK    = 2'b01,
    MAX_MASK    = 2'b10,
    MINMAX_MASK = 2'b11
  } _mask_mode;
endpackage

module pwm_carrier_counter
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [1:0]             count_mode,
  input  logic [1:0]             mask_mode,
  input  logic [CNT_WIDTH-1:0]   period_in,
  input  logic [PRESC_WIDTH-1:0] presc_in,
`ifdef PWM_SYNC_IN_EN
  input  logic                   sync_in,
`endif
  output logic [CNT_WIDTH-1:0]   carrier,
  output logic                   dir,
  output logic                   ev_min,
  output logic                   ev_max,
  output logic                   upd
);

  localparam logic [CNT_WIDTH-1:0]   CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESC_WIDTH-1:0] PRESC_ZERO = {PRESC_WIDTH{1'b0}};
  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE  = {{(PRESC_WIDTH-1){1'b0}}, 1'b1};

  // Shadow (active) configuration and prescaler state
  logic [CNT_WIDTH-1:0]   period_sh_r;
  logic [PRESC_WIDTH-1:0] presc_sh_r;
  logic [1:0]             mode_sh_r;
  logic [PRESC_WIDTH-1:0] presc_cnt_r;

  // Combinational next-state terms
  logic                 tick_s;
  logic                 mode_ok_s;
  logic                 step_s;
  logic [CNT_WIDTH-1:0] nxt_carrier_s;
  logic                 nxt_dir_s;
  logic                 ev_min_s;
  logic                 ev_max_s;
  logic                 reload_s;
  logic                 sync_s;

  // Sync request qualification; tied off when the feature is not built
  always_comb begin
`ifdef PWM_SYNC_IN_EN
    sync_s = en & sync_in;
`else
    sync_s = 1'b0;
`endif
  end

  // Prescaler tick: >= rather than == so that a reload with a smaller
  // divider while presc_cnt_r is already above it still ticks immediately
  always_comb begin
    if (en && (presc_cnt_r >= presc_sh_r)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Carrier next value and direction for the active count mode
  always_comb begin
    nxt_carrier_s = carrier;
    nxt_dir_s     = dir;
    mode_ok_s     = 1'b1;
    case (mode_sh_r)
      COUNT_UP: begin
        nxt_dir_s = 1'b1;
        // Wrap at P; an out-of-range carrier after a reload also wraps to 0
        if (carrier >= period_sh_r) begin
          nxt_carrier_s = CNT_ZERO;
        end else begin
          nxt_carrier_s = carrier + CNT_ONE;
        end
      end
      COUNT_DOWN: begin
        nxt_dir_s = 1'b0;
        if ((carrier == CNT_ZERO) || (carrier > period_sh_r)) begin
          nxt_carrier_s = period_sh_r;
        end else begin
          nxt_carrier_s = carrier - CNT_ONE;
        end
      end
      COUNT_UPDOWN: begin
        if (carrier > period_sh_r) begin
          nxt_carrier_s = period_sh_r;
          nxt_dir_s     = 1'b0;
        end else if (period_sh_r == CNT_ZERO) begin
          nxt_carrier_s = CNT_ZERO;
          nxt_dir_s     = 1'b1;
        end else if (dir) begin
          // Peak is shown once; direction flips on the tick leaving P
          if (carrier == period_sh_r) begin
            nxt_carrier_s = period_sh_r - CNT_ONE;
            nxt_dir_s     = 1'b0;
          end else begin
            nxt_carrier_s = carrier + CNT_ONE;
            nxt_dir_s     = 1'b1;
          end
        end else begin
          // Valley is shown once; direction flips on the tick leaving 0
          if (carrier == CNT_ZERO) begin
            nxt_carrier_s = CNT_ONE;
            nxt_dir_s     = 1'b1;
          end else begin
            nxt_carrier_s = carrier - CNT_ONE;
            nxt_dir_s     = 1'b0;
          end
        end
      end
      default: begin
        // Invalid mode: carrier frozen, no events, no reloads
        mode_ok_s = 1'b0;
      end
    endcase
  end

  // Event detection on the value being written, and mask-filtered reload
  always_comb begin
    step_s   = tick_s & mode_ok_s;
    ev_min_s = step_s & (nxt_carrier_s == CNT_ZERO);
    // With P=0 the carrier sits at 0, which is reported as a min event only
    ev_max_s = step_s & (nxt_carrier_s == period_sh_r) & (period_sh_r != CNT_ZERO);
    case (mask_mode)
      NO_MASK:     reload_s = ev_min_s | ev_max_s;
      MIN_MASK:    reload_s = ev_max_s;
      MAX_MASK:    reload_s = ev_min_s;
      MINMAX_MASK: reload_s = 1'b0;
      default:     reload_s = 1'b0;
    endcase
  end

  // Prescaler counter: sync clears it, en=0 holds it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_r <= PRESC_ZERO;
    end else if (sync_s) begin
      presc_cnt_r <= PRESC_ZERO;
    end else if (tick_s) begin
      presc_cnt_r <= PRESC_ZERO;
    end else if (en) begin
      presc_cnt_r <= presc_cnt_r + PRESC_ONE;
    end else begin
      presc_cnt_r <= presc_cnt_r;
    end
  end

  // Shadow registers: reload on qualified events or on sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_sh_r <= CNT_ZERO;
      presc_sh_r  <= PRESC_ZERO;
      mode_sh_r   <= COUNT_UP;
    end else if (sync_s || reload_s) begin
      period_sh_r <= period_in;
      presc_sh_r  <= presc_in;
      mode_sh_r   <= count_mode;
    end else begin
      period_sh_r <= period_sh_r;
      presc_sh_r  <= presc_sh_r;
      mode_sh_r   <= mode_sh_r;
    end
  end

  // Registered carrier, direction and event/update pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carrier <= CNT_ZERO;
      dir     <= 1'b1;
      ev_min  <= 1'b0;
      ev_max  <= 1'b0;
      upd     <= 1'b0;
    end else if (sync_s) begin
      carrier <= CNT_ZERO;
      dir     <= 1'b1;
      ev_min  <= 1'b1;
      ev_max  <= 1'b0;
      upd     <= 1'b1;
    end else if (step_s) begin
      carrier <= nxt_carrier_s;
      dir     <= nxt_dir_s;
      ev_min  <= ev_min_s;
      ev_max  <= ev_max_s;
      upd     <= reload_s;
    end else begin
      carrier <= carrier;
      dir     <= dir;
      ev_min  <= 1'b0;
      ev_max  <= 1'b0;
      upd     <= 1'b0;
    end
  end

endmodule
